// File: rtl/iram_loader.sv
// Boot loader: assembles little-endian words from a byte stream, writes them to
// IRAM from address 0 and releases the CPU reset once the requested count is written.
module iram_loader #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              iram_we,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [31:0]       iram_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t            state, state_nx;
  logic [ADDR_W:0]   count, index, count_in;
  logic [1:0]        byte_cnt;
  logic [23:0]       part;
  logic              start_ok, hs, last_word;

  // Clamping keeps the word index inside the IRAM so iram_addr never wraps.
  assign count_in  = (word_count > DEPTH_C) ? DEPTH_C : word_count;
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign hs        = byte_valid && (state == RECV);
  assign last_word = ((index + ONE_C) == count);

  always_ff @(posedge clk_in) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (count_in == '0) ? DONE : RECV;
      RECV:       if (hs && byte_cnt == 2'd3) state_nx = WRITE;
      WRITE:      state_nx = last_word ? DONE : RECV;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state == RECV);
    iram_we    = (state == WRITE);
    busy       = (state == RECV) || (state == WRITE);
    done       = (state == DONE);
    cpu_reset  = (state != DONE);
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      count      <= '0;
      index      <= '0;
      byte_cnt   <= '0;
      part       <= '0;
      iram_addr  <= '0;
      iram_wdata <= '0;
      checksum   <= '0;
    end else begin
      if (start_ok) begin
        count    <= count_in;
        index    <= '0;
        byte_cnt <= '0;
        part     <= '0;
        checksum <= '0;
      end
      if (hs) begin
        byte_cnt <= byte_cnt + 2'd1;
        // Byte 3 completes the word; the write port registers take it directly.
        if (byte_cnt == 2'd3) begin
          iram_wdata <= {byte_data, part};
          iram_addr  <= index[ADDR_W-1:0];
        end else begin
          part[8*byte_cnt +: 8] <= byte_data;
        end
      end
      if (state == WRITE) begin
        checksum <= checksum + iram_wdata;
        index    <= index + ONE_C;
      end
    end
  end

endmodule

// File: tb/tb_iram_loader.sv
// Randomized bench for iram_loader: a queue of expected IRAM writes and a running
// sum model the load; one negedge process checks every write and output invariants.
module tb_iram_loader;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              clk_in = 0;
  logic              reset = 0;
  logic              start = 0;
  logic [ADDR_W:0]   word_count = '0;
  logic              byte_valid = 0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready, iram_we, cpu_reset, busy, done;
  logic [ADDR_W-1:0] iram_addr;
  logic [31:0]       iram_wdata, checksum;

  iram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .iram_we(iram_we), .iram_addr(iram_addr), .iram_wdata(iram_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          next_addr;
  logic [31:0] model_sum;
  int          n_cmp = 0, n_bad = 0;
  bit          chk_en = 0, tput_chk = 0, have_prev = 0;
  int          cyc = 0, prev_we_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    cyc++;
    if (chk_en) begin
      chk("cpu_reset_vs_done", 32'(cpu_reset), 32'(!done));
      if (byte_ready) chk("ready_implies_busy", 32'(busy), 32'd1);
      if (iram_we) begin
        chk("we_implies_busy", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          chk("spurious_we", 32'(iram_we), 32'd0);
        end else begin
          chk("wr_addr", 32'(iram_addr), 32'(exp_q[0].addr));
          chk("wr_data", iram_wdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        if (tput_chk && have_prev) chk("throughput", 32'(cyc - prev_we_cyc), 32'd5);
        prev_we_cyc = cyc;
        have_prev   = 1;
      end
    end
  end

  task automatic push_exp(input logic [31:0] w);
    wr_t e;
    e.addr = next_addr;
    e.data = w;
    exp_q.push_back(e);
    next_addr++;
    model_sum += w;
  endtask

  // Returns at the negedge following the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int gap, t;
    gap = $urandom_range(0, gapmax);
    repeat (gap) begin
      byte_valid = 0;
      byte_data  = 8'($urandom);
      @(negedge clk_in);
    end
    byte_valid = 1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk_in);
      t++;
    end
    if (!byte_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL byte_ready_timeout: got 0 want 1");
    end
    @(negedge clk_in);
    byte_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    push_exp(w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gapmax);
  endtask

  task automatic start_load(input int wc);
    int n;
    n = (wc > DEPTH) ? DEPTH : wc;
    @(negedge clk_in);
    exp_q.delete();
    next_addr = 0;
    model_sum = 0;
    have_prev = 0;
    start      = 1;
    word_count = (ADDR_W+1)'(wc);
    @(negedge clk_in);
    start = 0;
    chk("start_checksum_clear", checksum, 32'd0);
    if (n == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_cpu_reset", 32'(cpu_reset), 32'd0);
    end else begin
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_ready", 32'(byte_ready), 32'd1);
      chk("start_done_low", 32'(done), 32'd0);
    end
  endtask

  // Called at the negedge of the final WRITE cycle.
  task automatic finish_load();
    chk("last_we", 32'(iram_we), 32'd1);
    chk("last_not_done", 32'(done), 32'd0);
    @(negedge clk_in);
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("fin_busy", 32'(busy), 32'd0);
    chk("fin_checksum", checksum, model_sum);
    chk("fin_all_written", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    // Reset
    repeat (2) @(negedge clk_in);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(iram_we), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    reset  = 1;
    chk_en = 1;

    // Single word, back to back
    start_load(1);
    send_word(32'h12345678, 0);
    finish_load();
    chk("single_checksum_lit", checksum, 32'h12345678);

    // Three words with random gaps, checksum wraps
    start_load(3);
    send_word(32'hFFFFFFFF, 4);
    send_word(32'h00000002, 4);
    send_word(32'hDEADBEEF, 4);
    finish_load();
    chk("three_checksum_lit", checksum, 32'hDEADBEF0);

    // Zero-length load
    start_load(0);
    repeat (6) @(negedge clk_in);
    chk("zero_hold_done", 32'(done), 32'd1);
    chk("zero_checksum", checksum, 32'd0);

    // Starts mid-load are ignored (in RECV and in WRITE)
    start_load(2);
    push_exp(32'hCAFEF00D);
    send_byte(8'h0D, 0);
    start = 1; word_count = 1;
    @(negedge clk_in);
    start = 0;
    chk("ign_start_busy", 32'(busy), 32'd1);
    send_byte(8'hF0, 2);
    send_byte(8'hFE, 2);
    send_byte(8'hCA, 2);
    start = 1; word_count = 1;
    @(negedge clk_in);
    start = 0;
    chk("ign_write_busy", 32'(busy), 32'd1);
    send_word(32'h0BADC0DE, 2);
    finish_load();

    // Restart from DONE
    start_load(1);
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    send_word(32'h55AA33CC, 1);
    finish_load();

    // Reset mid-word drops the partial word
    start_load(2);
    send_word(32'h01020304, 1);
    send_byte(8'h99, 0);
    send_byte(8'h88, 0);
    reset = 0;
    @(negedge clk_in);
    reset = 1;
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(byte_ready), 32'd0);
    chk("midrst_checksum", checksum, 32'd0);
    start_load(1);
    send_word(32'hA5A50F0F, 0);
    finish_load();

    // Random loads
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      start_load(n);
      for (int i = 0; i < n; i++) send_word($urandom, 3);
      finish_load();
    end

    // Oversized word_count clamps to DEPTH; valid held high gives peak rate
    start_load(4095);
    tput_chk = 1;
    for (int i = 0; i < DEPTH; i++) send_word($urandom, 0);
    finish_load();
    tput_chk = 0;
    repeat (3) @(negedge clk_in);
    chk("clamp_stays_done", 32'(done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/iram_loader.md
# iram_loader

Boot-time writer for the instruction RAM that the CPU reads on its instruction port. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive IRAM word addresses starting at 0. It holds the CPU in reset until the programmed number of words has been written. It sits beside the CPU/IRAM/DRAM top level and drives the IRAM write port and the CPU reset.

## Interface
- ADDR_W, 11, IRAM word-address width (word address = byte address [12:2])
- DEPTH, 2048, IRAM depth in words; must equal 2**ADDR_W
- clk_in  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE
- word_count  in  ADDR_W+1  number of words to load; sampled on an honoured start
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- iram_we  out  1  IRAM write strobe, one cycle per word
- iram_addr  out  ADDR_W  IRAM word address
- iram_wdata  out  32  IRAM write data
- cpu_reset  out  1  active-high reset to the CPU
- busy  out  1  load in progress (RECV or WRITE)
- done  out  1  last load completed
- checksum  out  32  modulo-2^32 sum of all words written in the current or last load

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- Reset (reset=0 at a clock edge) forces IDLE and clears all state. Outputs: byte_ready=0, iram_we=0, iram_addr=0, iram_wdata=0, cpu_reset=1, busy=0, done=0, checksum=0. The byte counter, word index and partial word are cleared.
- IDLE: cpu_reset=1. A start sets count = min(word_count, DEPTH) and clears the index, byte counter and checksum.
  - If count == 0, go to DONE.
  - Otherwise go to RECV.
- RECV: byte_ready=1. A handshake occurs when byte_valid && byte_ready.
  - Byte k (k = 0..3) of a word is placed in bits [8k+7:8k].
  - The handshake that delivers byte 3 moves the FSM to WRITE.
- WRITE, one cycle: byte_ready=0, iram_we=1, iram_addr=index, iram_wdata=assembled word.
  - checksum += word, wrapping modulo 2^32.
  - index increments.
  - If index+1 == count, go to DONE; otherwise go to RECV with the byte counter at 0.
- DONE: done=1, cpu_reset=0, byte_ready=0. checksum holds its value.
  - A start restarts exactly as from IDLE: done drops, cpu_reset rises and checksum clears.
- start is ignored in RECV and WRITE. byte_valid is ignored outside RECV.
- busy = (state == RECV || state == WRITE).
- A reset during RECV or WRITE discards the partial word. Words already written stay in IRAM, and cpu_reset stays asserted.
- word_count greater than DEPTH is clamped to DEPTH, so iram_addr never wraps.

## Timing
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- start at edge n: busy=1 and byte_ready=1 from cycle n+1. With count == 0, done=1 and cpu_reset=0 from cycle n+1 instead.
- Byte-3 handshake at edge n: iram_we=1 during cycle n+1, and IRAM captures the word at edge n+1. byte_ready returns at n+2 unless the load is finishing.
- Last word: done=1 and cpu_reset=0 from cycle n+2, where edge n carries that word's byte-3 handshake.
- Peak throughput: one word per 5 cycles with byte_valid held high.
- iram_we is 0 in every state except WRITE. iram_addr and iram_wdata hold their last value outside WRITE.

## Test plan
- Reset: hold reset=0 for 2 cycles.
  - Expect cpu_reset=1, busy=0, done=0, byte_ready=0, iram_we=0 and checksum=0.
- Single word: start with word_count=1, then bytes 0x78, 0x56, 0x34, 0x12 back to back.
  - Expect one iram_we pulse with addr 0 and data 0x12345678.
  - Then done=1, cpu_reset=0 and checksum=0x12345678.
- Three words with random byte_valid gaps: data 0xFFFFFFFF, 0x00000002, 0xDEADBEEF.
  - Expect writes to addr 0, 1, 2 in order and checksum=0xDEADBEF0 (wrap).
  - Expect no handshake while byte_valid=0.
- word_count=0: expect done=1 and cpu_reset=0 one cycle after start, with no iram_we pulse.
- Ignored start and restart: pulse start mid-load and expect no effect. Pulse start in DONE.
  - Expect done=0, cpu_reset=1, checksum=0, and a new load beginning at addr 0.
- Reset mid-word: reset=0 after 2 bytes of word 1.
  - Expect state IDLE and cpu_reset=1.
  - After a fresh start, the next 4 bytes form a word written to addr 0, with no leftover bytes included.
